instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the instruction decoder.
- Holds the PC and issues word reads to instruction memory over a request/grant plus in-order response interface.
- Buffers returned words in a small FIFO and presents them to the decoder with a valid/ready handshake.
- Accepts a redirect (new PC) that flushes the FIFO and discards in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BUF_DEPTH, 2, instruction FIFO entries; power of two, >= 2. Also the cap on (occupancy + outstanding requests).

Ports:
- ip_clk  input  1  clock; all state updates on rising edge.
- ip_rst_n  input  1  synchronous active-low reset.
- op_imem_req  output  1  read request valid.
- op_imem_addr  output  32  word address of request (= PC, bits[1:0] always 0).
- ip_imem_gnt  input  1  request accepted this cycle when op_imem_req && ip_imem_gnt.
- ip_imem_rdata_valid  input  1  one response word this cycle, in request order.
- ip_imem_rdata  input  32  response word.
- ip_redirect  input  1  load new PC and flush.
- ip_redirect_pc  input  32  target PC; bits[1:0] forced to 0.
- op_instr  output  32  instruction at FIFO head (feeds decoder instruction input).
- op_instr_pc  output  32  PC of op_instr.
- op_instr_valid  output  1  FIFO head valid (feeds decoder valid input).
- ip_instr_ready  input  1  consumer takes head when op_instr_valid && ip_instr_ready.

Behaviour:
- Reset (ip_rst_n=0 at edge): PC=RESET_PC, FIFO empty, outstanding=0, discard_cnt=0, state=S_IDLE. Outputs after reset edge: op_imem_req=0, op_instr_valid=0, op_instr=0, op_instr_pc=0, op_imem_addr=RESET_PC. Reset mid-operation aborts everything; later responses are ignored because outstanding=0.
- States:
  - S_IDLE: one cycle after reset, no requests; then -> S_FETCH.
  - S_FETCH: op_imem_req=1 iff occupancy+outstanding < BUF_DEPTH; no lookahead on pop. On grant: PC+=4 (wraps 32'hFFFF_FFFC -> 0), outstanding+1; the request's PC goes into a PC tag queue.
  - S_FLUSH: entered on redirect when post-cycle in-flight count > 0. op_imem_req=0. Each response decrements discard_cnt and is dropped. -> S_FETCH when discard_cnt reaches 0 (request may assert the following cycle). A redirect with zero in-flight goes straight to S_FETCH.
- Response (S_FETCH): word and tag-queue PC pushed to FIFO, outstanding-1. Registered path, no bypass: op_instr_valid rises the cycle after ip_imem_rdata_valid when the FIFO was empty (latency 1).
- Pop: on valid&&ready. Push and pop in the same cycle leaves occupancy unchanged, including when full. Overflow cannot occur because of the credit rule.
- Redirect priority: highest.
  - Same cycle: PC<=ip_redirect_pc&~3, FIFO cleared, op_instr_valid=0 next cycle.
  - discard_cnt <= outstanding + grant_this_cycle - rdata_this_cycle.
  - A response arriving in the redirect cycle is dropped.
  - A grant in the redirect cycle is counted for discard.
  - A pop in the redirect cycle still completes for the consumer.
  - Redirect while in S_FLUSH: PC updated again, discard_cnt recomputed by the same rule.
- ip_imem_rdata_valid with outstanding=0 and not in S_FLUSH: ignored, no state change.
- op_instr/op_instr_pc hold their value while valid&&!ready (stable-under-stall); they are don't-care when invalid, but are driven from the FIFO head.

Test Plan:
- Reset, gnt=1, rdata_valid one cycle after each grant, ready=1 -> addresses 0x0,0x4,0x8…; op_instr_valid first high 3 cycles after reset deassert; op_instr_pc 0x0,0x4,0x8 in order with matching words.
- ready=0 for 10 cycles, memory always grants and responds -> exactly BUF_DEPTH=2 requests issued, op_imem_req low thereafter, op_instr stable at PC 0x0 word; releasing ready resumes at 0x8.
- Two requests outstanding (0x10,0x14), ip_redirect with pc 0x103 -> both late responses dropped, no op_instr_valid until response for 0x100; next addresses 0x100,0x104.
- Redirect in same cycle as grant of 0x20 and rdata for 0x1C -> 0x1C not presented, 0x20 discarded, discard_cnt correct, fetch resumes at target.
- Spurious ip_imem_rdata_valid after reset with no request -> op_instr_valid stays 0, first real fetch still PC RESET_PC.
- PC at 0xFFFF_FFFC granted -> next op_imem_addr 0x0000_0000.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC and issues word reads to instruction memory.
// Returned words are buffered in a small FIFO and handed to the decoder with valid/ready.
// A redirect loads a new PC, empties the FIFO and drops every response still in flight.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        ip_clk,
    input  logic        ip_rst_n,
    output logic        op_imem_req,
    output logic [31:0] op_imem_addr,
    input  logic        ip_imem_gnt,
    input  logic        ip_imem_rdata_valid,
    input  logic [31:0] ip_imem_rdata,
    input  logic        ip_redirect,
    input  logic [31:0] ip_redirect_pc,
    output logic [31:0] op_instr,
    output logic [31:0] op_instr_pc,
    output logic        op_instr_valid,
    input  logic        ip_instr_ready
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(BUF_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [31:0]   pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard_cnt;
    logic [CW-1:0] inflight_next;
    logic [CW-1:0] fifo_cnt;
    logic [CW:0]   credit_used;

    logic [PW-1:0] tag_rd;
    logic [PW-1:0] tag_wr;
    logic [PW-1:0] fifo_rd;
    logic [PW-1:0] fifo_wr;

    logic [31:0]   tag_mem   [BUF_DEPTH];
    logic [31:0]   instr_mem [BUF_DEPTH];
    logic [31:0]   pc_mem    [BUF_DEPTH];

    logic          req;
    logic          grant;
    logic          rsp_any;
    logic          push;
    logic          pop;

    // Words already buffered plus words still owed by memory; a request only goes out
    // when this total leaves room, so the FIFO can never be overrun.
    assign credit_used = {1'b0, fifo_cnt} + {1'b0, outstanding};

    // Request gating: only in FETCH and only while a buffer slot is still unclaimed.
    always_comb begin
        req = 1'b0;
        if (state == S_FETCH && credit_used < DEPTH_C) begin
            req = 1'b1;
        end
    end

    assign grant   = req && ip_imem_gnt;
    // A response is only meaningful if something is owed; stray strobes are ignored.
    assign rsp_any = ip_imem_rdata_valid && (outstanding != '0);
    // A response arriving in a redirect cycle belongs to the old stream and is dropped.
    assign push    = rsp_any && (state == S_FETCH) && !ip_redirect;
    assign pop     = op_instr_valid && ip_instr_ready;

    assign inflight_next = outstanding + CW'(grant) - CW'(rsp_any);

    // Next-state logic; a redirect overrides everything and waits only if responses are owed.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = S_FETCH;
            S_FETCH: state_next = S_FETCH;
            S_FLUSH: begin
                if (discard_cnt == '0 || (rsp_any && discard_cnt == CW'(1))) begin
                    state_next = S_FETCH;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (ip_redirect) begin
            state_next = (inflight_next != '0) ? S_FLUSH : S_FETCH;
        end
    end

    // State register.
    always_ff @(posedge ip_clk) begin
        if (!ip_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // PC, in-flight accounting and the PC tag queue pointers.
    always_ff @(posedge ip_clk) begin
        if (!ip_rst_n) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            discard_cnt <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
        end else begin
            outstanding <= inflight_next;
            if (ip_redirect) begin
                pc          <= ip_redirect_pc & ~32'h0000_0003;
                discard_cnt <= inflight_next;
                tag_rd      <= '0;
                tag_wr      <= '0;
            end else begin
                if (grant) begin
                    pc     <= pc + 32'd4;
                    tag_wr <= tag_wr + PW'(1);
                end
                if (push) begin
                    tag_rd <= tag_rd + PW'(1);
                end
                if (state == S_FLUSH && rsp_any) begin
                    discard_cnt <= discard_cnt - CW'(1);
                end
            end
        end
    end

    // Tag queue storage: remembers the PC of each granted request until its word returns.
    always_ff @(posedge ip_clk) begin
        if (grant) begin
            tag_mem[tag_wr] <= pc;
        end
    end

    // Instruction FIFO; storage is cleared on reset so the head reads zero afterwards.
    always_ff @(posedge ip_clk) begin
        if (!ip_rst_n) begin
            fifo_rd  <= '0;
            fifo_wr  <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else if (ip_redirect) begin
            fifo_rd  <= '0;
            fifo_wr  <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                instr_mem[fifo_wr] <= ip_imem_rdata;
                pc_mem[fifo_wr]    <= tag_mem[tag_rd];
                fifo_wr            <= fifo_wr + PW'(1);
            end
            if (pop) begin
                fifo_rd <= fifo_rd + PW'(1);
            end
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
        end
    end

    assign op_imem_req    = req;
    assign op_imem_addr   = pc;
    assign op_instr       = instr_mem[fifo_rd];
    assign op_instr_pc    = pc_mem[fifo_rd];
    assign op_instr_valid = (fifo_cnt != '0);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a one-cycle-latency instruction memory model.
module tb_instr_fetch_unit;

    logic        ip_clk;
    logic        ip_rst_n;
    logic        op_imem_req;
    logic [31:0] op_imem_addr;
    logic        ip_imem_gnt;
    logic        ip_imem_rdata_valid;
    logic [31:0] ip_imem_rdata;
    logic        ip_redirect;
    logic [31:0] ip_redirect_pc;
    logic [31:0] op_instr;
    logic [31:0] op_instr_pc;
    logic        op_instr_valid;
    logic        ip_instr_ready;

    int tests_run;
    int tests_failed;

    bit gnt_en;
    bit rsp_en;
    bit spur;

    logic [31:0] pend_q[$];
    logic [31:0] gnt_log[$];
    logic [31:0] pop_pc_log[$];
    logic [31:0] pop_ins_log[$];

    logic        smp_req;
    logic [31:0] smp_addr;
    logic        smp_valid;
    logic [31:0] smp_pc;
    logic [31:0] smp_ins;
    int          seen_valid;

    instr_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .ip_clk              (ip_clk),
        .ip_rst_n            (ip_rst_n),
        .op_imem_req         (op_imem_req),
        .op_imem_addr        (op_imem_addr),
        .ip_imem_gnt         (ip_imem_gnt),
        .ip_imem_rdata_valid (ip_imem_rdata_valid),
        .ip_imem_rdata       (ip_imem_rdata),
        .ip_redirect         (ip_redirect),
        .ip_redirect_pc      (ip_redirect_pc),
        .op_instr            (op_instr),
        .op_instr_pc         (op_instr_pc),
        .op_instr_valid      (op_instr_valid),
        .ip_instr_ready      (ip_instr_ready)
    );

    initial ip_clk = 1'b0;
    always #5 ip_clk = ~ip_clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~a;
    endfunction

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hXXXX_XXXX;
    endfunction

    // One clock: drive inputs at the falling edge, sample outputs there, book-keep at the rising edge.
    task automatic step(input bit redir, input logic [31:0] rpc);
        bit g;
        bit r;
        bit p;
        logic [31:0] ga;
        @(negedge ip_clk);
        r = rsp_en && (pend_q.size() > 0);
        ip_imem_gnt         = gnt_en;
        ip_imem_rdata_valid = r || spur;
        ip_imem_rdata       = r ? mem_word(pend_q[0]) : 32'hBAD0_0BAD;
        ip_redirect         = redir;
        ip_redirect_pc      = rpc;
        smp_req   = op_imem_req;
        smp_addr  = op_imem_addr;
        smp_valid = op_instr_valid;
        smp_pc    = op_instr_pc;
        smp_ins   = op_instr;
        if (op_instr_valid) seen_valid++;
        g  = op_imem_req && gnt_en;
        ga = op_imem_addr;
        p  = op_instr_valid && ip_instr_ready;
        if (p) begin
            pop_pc_log.push_back(op_instr_pc);
            pop_ins_log.push_back(op_instr);
        end
        @(posedge ip_clk);
        if (g) begin
            pend_q.push_back(ga);
            gnt_log.push_back(ga);
        end
        if (r) void'(pend_q.pop_front());
        #1;
        ip_redirect = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge ip_clk);
        ip_rst_n            = 1'b0;
        ip_imem_gnt         = 1'b0;
        ip_imem_rdata_valid = 1'b0;
        ip_imem_rdata       = 32'h0;
        ip_redirect         = 1'b0;
        ip_redirect_pc      = 32'h0;
        ip_instr_ready      = 1'b0;
        gnt_en = 1'b0;
        rsp_en = 1'b0;
        spur   = 1'b0;
        repeat (2) @(posedge ip_clk);
        @(negedge ip_clk);
        pend_q.delete();
        gnt_log.delete();
        pop_pc_log.delete();
        pop_ins_log.delete();
        seen_valid = 0;
        ip_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        gnt_en = 1'b1;
        rsp_en = 1'b1;
        repeat (6) step(1'b0, 32'h0);
        // Reset again with the FIFO holding words and the PC advanced.
        do_reset();
        tests_run++;
        if (op_imem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_req got=%b exp=0", op_imem_req);
        end
        tests_run++;
        if (op_instr_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_valid got=%b exp=0", op_instr_valid);
        end
        tests_run++;
        if (op_instr !== 32'h0 || op_instr_pc !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_instr got=%h/%h exp=0/0", op_instr, op_instr_pc);
        end
        tests_run++;
        if (op_imem_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_addr got=%h exp=00000000", op_imem_addr);
        end
    endtask

    task automatic test_basic();
        int first_v;
        do_reset();
        gnt_en = 1'b1;
        rsp_en = 1'b1;
        ip_instr_ready = 1'b1;
        first_v = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1'b0, 32'h0);
            if (smp_valid && first_v == 0) first_v = i;
        end
        tests_run++;
        if (first_v !== 3) begin
            tests_failed++;
            $display("FAIL basic_latency got=%0d exp=3", first_v);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (qget(gnt_log, i) !== 32'(i * 4)) begin
                tests_failed++;
                $display("FAIL basic_addr[%0d] got=%h exp=%h", i, qget(gnt_log, i), 32'(i * 4));
            end
        end
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (qget(pop_pc_log, i) !== 32'(i * 4) || qget(pop_ins_log, i) !== mem_word(32'(i * 4))) begin
                tests_failed++;
                $display("FAIL basic_pop[%0d] got=%h/%h exp=%h/%h", i, qget(pop_pc_log, i),
                         qget(pop_ins_log, i), 32'(i * 4), mem_word(32'(i * 4)));
            end
        end
    endtask

    task automatic test_stall();
        int unstable;
        do_reset();
        gnt_en = 1'b1;
        rsp_en = 1'b1;
        ip_instr_ready = 1'b0;
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 32'h0);
            if (smp_valid && (smp_pc !== 32'h0 || smp_ins !== mem_word(32'h0))) unstable++;
        end
        tests_run++;
        if (gnt_log.size() !== 2) begin
            tests_failed++;
            $display("FAIL stall_req_count got=%0d exp=2", gnt_log.size());
        end
        tests_run++;
        if (smp_req !== 1'b0 || smp_valid !== 1'b1 || smp_pc !== 32'h0) begin
            tests_failed++;
            $display("FAIL stall_state got req=%b vld=%b pc=%h exp req=0 vld=1 pc=0", smp_req, smp_valid, smp_pc);
        end
        tests_run++;
        if (unstable !== 0) begin
            tests_failed++;
            $display("FAIL stall_stable got=%0d changes exp=0", unstable);
        end
        ip_instr_ready = 1'b1;
        step(1'b0, 32'h0);
        tests_run++;
        if (smp_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_no_lookahead got=%b exp=0", smp_req);
        end
        repeat (7) step(1'b0, 32'h0);
        tests_run++;
        if (qget(gnt_log, 2) !== 32'h8) begin
            tests_failed++;
            $display("FAIL stall_resume_addr got=%h exp=00000008", qget(gnt_log, 2));
        end
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (qget(pop_pc_log, i) !== 32'(i * 4) || qget(pop_ins_log, i) !== mem_word(32'(i * 4))) begin
                tests_failed++;
                $display("FAIL stall_pop[%0d] got=%h/%h exp=%h", i, qget(pop_pc_log, i),
                         qget(pop_ins_log, i), 32'(i * 4));
            end
        end
    endtask

    task automatic test_redirect_flush();
        int v_flush;
        do_reset();
        ip_instr_ready = 1'b1;
        step(1'b1, 32'h0000_0010);
        gnt_en = 1'b1;
        repeat (2) step(1'b0, 32'h0);
        step(1'b0, 32'h0);
        tests_run++;
        if (smp_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_credit_full got=%b exp=0", smp_req);
        end
        step(1'b1, 32'h0000_0103);
        rsp_en = 1'b1;
        v_flush = 0;
        step(1'b0, 32'h0);
        v_flush += smp_valid + smp_req;
        step(1'b0, 32'h0);
        v_flush += smp_valid + smp_req;
        tests_run++;
        if (v_flush !== 0) begin
            tests_failed++;
            $display("FAIL flush_quiet got=%0d exp=0", v_flush);
        end
        step(1'b0, 32'h0);
        tests_run++;
        if (smp_req !== 1'b1 || smp_addr !== 32'h0000_0100) begin
            tests_failed++;
            $display("FAIL flush_resume got req=%b addr=%h exp req=1 addr=00000100", smp_req, smp_addr);
        end
        repeat (6) step(1'b0, 32'h0);
        tests_run++;
        if (qget(gnt_log, 0) !== 32'h10 || qget(gnt_log, 1) !== 32'h14 ||
            qget(gnt_log, 2) !== 32'h100 || qget(gnt_log, 3) !== 32'h104) begin
            tests_failed++;
            $display("FAIL flush_addrs got=%h,%h,%h,%h exp=10,14,100,104", qget(gnt_log, 0),
                     qget(gnt_log, 1), qget(gnt_log, 2), qget(gnt_log, 3));
        end
        tests_run++;
        if (qget(pop_pc_log, 0) !== 32'h100 || qget(pop_ins_log, 0) !== mem_word(32'h100)) begin
            tests_failed++;
            $display("FAIL flush_first_pop got=%h/%h exp=00000100/%h", qget(pop_pc_log, 0),
                     qget(pop_ins_log, 0), mem_word(32'h100));
        end
    endtask

    task automatic test_redirect_same_cycle();
        do_reset();
        ip_instr_ready = 1'b1;
        rsp_en = 1'b1;
        step(1'b1, 32'h0000_001C);
        gnt_en = 1'b1;
        step(1'b0, 32'h0);
        step(1'b1, 32'h0000_0200);
        tests_run++;
        if (qget(gnt_log, 1) !== 32'h20) begin
            tests_failed++;
            $display("FAIL same_grant got=%h exp=00000020", qget(gnt_log, 1));
        end
        step(1'b0, 32'h0);
        tests_run++;
        if (smp_req !== 1'b0 || smp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL same_flush got req=%b vld=%b exp 0/0", smp_req, smp_valid);
        end
        step(1'b0, 32'h0);
        tests_run++;
        if (smp_req !== 1'b1 || smp_addr !== 32'h200) begin
            tests_failed++;
            $display("FAIL same_resume got req=%b addr=%h exp req=1 addr=00000200", smp_req, smp_addr);
        end
        repeat (6) step(1'b0, 32'h0);
        tests_run++;
        if (qget(pop_pc_log, 0) !== 32'h200 || qget(pop_ins_log, 0) !== mem_word(32'h200)) begin
            tests_failed++;
            $display("FAIL same_first_pop got=%h/%h exp=00000200/%h", qget(pop_pc_log, 0),
                     qget(pop_ins_log, 0), mem_word(32'h200));
        end
    endtask

    task automatic test_spurious();
        do_reset();
        ip_instr_ready = 1'b1;
        spur = 1'b1;
        repeat (3) step(1'b0, 32'h0);
        spur = 1'b0;
        tests_run++;
        if (seen_valid !== 0) begin
            tests_failed++;
            $display("FAIL spur_valid got=%0d cycles exp=0", seen_valid);
        end
        gnt_en = 1'b1;
        rsp_en = 1'b1;
        repeat (6) step(1'b0, 32'h0);
        tests_run++;
        if (qget(gnt_log, 0) !== 32'h0) begin
            tests_failed++;
            $display("FAIL spur_first_addr got=%h exp=00000000", qget(gnt_log, 0));
        end
        tests_run++;
        if (qget(pop_pc_log, 0) !== 32'h0 || qget(pop_ins_log, 0) !== mem_word(32'h0)) begin
            tests_failed++;
            $display("FAIL spur_first_pop got=%h/%h exp=00000000/%h", qget(pop_pc_log, 0),
                     qget(pop_ins_log, 0), mem_word(32'h0));
        end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        ip_instr_ready = 1'b1;
        rsp_en = 1'b1;
        step(1'b1, 32'hFFFF_FFFC);
        gnt_en = 1'b1;
        repeat (8) step(1'b0, 32'h0);
        tests_run++;
        if (qget(gnt_log, 0) !== 32'hFFFF_FFFC || qget(gnt_log, 1) !== 32'h0 || qget(gnt_log, 2) !== 32'h4) begin
            tests_failed++;
            $display("FAIL wrap_addrs got=%h,%h,%h exp=fffffffc,00000000,00000004", qget(gnt_log, 0),
                     qget(gnt_log, 1), qget(gnt_log, 2));
        end
        tests_run++;
        if (qget(pop_pc_log, 0) !== 32'hFFFF_FFFC || qget(pop_pc_log, 1) !== 32'h0 ||
            qget(pop_ins_log, 1) !== mem_word(32'h0)) begin
            tests_failed++;
            $display("FAIL wrap_pops got=%h,%h/%h exp=fffffffc,00000000/%h", qget(pop_pc_log, 0),
                     qget(pop_pc_log, 1), qget(pop_ins_log, 1), mem_word(32'h0));
        end
    endtask

    initial begin
        tests_run           = 0;
        tests_failed        = 0;
        ip_rst_n            = 1'b0;
        ip_imem_gnt         = 1'b0;
        ip_imem_rdata_valid = 1'b0;
        ip_imem_rdata       = 32'h0;
        ip_redirect         = 1'b0;
        ip_redirect_pc      = 32'h0;
        ip_instr_ready      = 1'b0;
        gnt_en              = 1'b0;
        rsp_en              = 1'b0;
        spur                = 1'b0;
        seen_valid          = 0;
        test_reset();
        test_basic();
        test_stall();
        test_redirect_flush();
        test_redirect_same_cycle();
        test_spurious();
        test_pc_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
